axi_slave_rd_responder: RTL and testbench

AXI4 read-channel responder (slave). It accepts AR requests from a read master such as the memcopy/test-engine read master. It queues the requests and returns R bursts whose data follow a deterministic incrementing pattern, so a master-side checker can verify them. Benches and loopback builds use it in place of host memory to exercise and check AXI read masters.

---
 rtl/axi_slave_rd_responder_pkg.sv | 20 ++
 rtl/axi_slave_rd_responder_fifo.sv | 57 +++++
 rtl/axi_slave_rd_responder.sv | 190 +++++++++++++++++++
 tb/tb_axi_slave_rd_responder.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_rd_responder_pkg.sv
// Shared definitions for the AXI read-channel responder.
// Contents: AXI burst/response encodings, responder FSM state type and the
// width of one queued AR request entry ({id, len, err}).
package axi_slave_rd_responder_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } rd_state_t;

   // One queued request: ID, 8-bit arlen and the address/burst error flag.
   function automatic int fifo_entry_w(input int id_w);
      return id_w + 8 + 1;
   endfunction

endpackage

// File: rtl/axi_slave_rd_responder_fifo.sv
// rd_req_fifo: synchronous FIFO of depth 2**AW holding AR requests.
// Ports:
//   clk, rst          clock, async active-high reset (pointers/count only)
//   i_push, i_data    write strobe and entry; ignored when full
//   i_pop             read strobe; ignored when empty
//   o_data            head entry, valid while o_empty is low
//   o_full, o_empty   occupancy flags
module rd_req_fifo #(
   parameter int W  = 11,
   parameter int AW = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/axi_slave_rd_responder.sv
// axi_slave_rd_responder: in-order AXI4 read slave returning an incrementing
// 32-bit pattern replicated across every lane of rdata.
// Ports:
//   clk, rst            clock, async active-high reset
//   s_axi_ar*           AR channel (aruser accepted and ignored)
//   s_axi_r*            R channel
//   i_init_data         pattern seed; each lane = seed + beats delivered
//   i_addr_base/limit   inclusive legal byte range; violations get SLVERR
//   i_clear             pulse: zero counters and restart the pattern
//   o_burst_count       completed bursts, o_beat_count completed beats
//   o_err_count         SLVERR bursts, saturating
module axi_slave_rd_responder
   import axi_slave_rd_responder_pkg::*;
#(
   parameter int ID_WIDTH     = 2,
   parameter int ADDR_WIDTH   = 64,
   parameter int DATA_WIDTH   = 512,
   parameter int ARUSER_WIDTH = 8,
   parameter int FIFO_AW      = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ID_WIDTH-1:0]     s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [ID_WIDTH-1:0]     s_axi_rid,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   input  logic [31:0]             i_init_data,
   input  logic [63:0]             i_addr_base,
   input  logic [63:0]             i_addr_limit,
   input  logic                    i_clear,
   output logic [31:0]             o_burst_count,
   output logic [39:0]             o_beat_count,
   output logic [15:0]             o_err_count
);

   localparam int ENTRY_W = fifo_entry_w(ID_WIDTH);
   localparam int LANES   = DATA_WIDTH / 32;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   rd_state_t             r_state;
   logic [ID_WIDTH-1:0]   r_rid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;
   logic                  r_rlast;
   logic                  r_rvalid;
   logic [7:0]            r_len;
   logic [7:0]            r_beat;
   logic                  r_err;
   logic [31:0]           r_pat_cnt;
   logic [31:0]           r_burst_cnt;
   logic [39:0]           r_beat_cnt;
   logic [15:0]           r_err_cnt;

   logic [ADDR_WIDTH:0]   w_addr_ext;
   logic [ADDR_WIDTH:0]   w_bytes;
   logic [ADDR_WIDTH:0]   w_end;
   logic [ADDR_WIDTH:0]   w_base_ext;
   logic [ADDR_WIDTH:0]   w_limit_ext;
   logic                  w_ar_err;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [ENTRY_W-1:0]    w_head;
   logic [ID_WIDTH-1:0]   w_head_id;
   logic [7:0]            w_head_len;
   logic                  w_head_err;
   logic                  w_beat_hs;
   logic [31:0]           w_pat_next;
   logic                  w_unused;

   assign w_unused = ^s_axi_aruser;

   // Last byte of the burst, one bit wider than the address so a wrap past
   // the top of the address space shows up as a value above any limit.
   assign w_addr_ext  = {1'b0, s_axi_araddr};
   assign w_bytes     = (ADDR_WIDTH+1)'({1'b0, s_axi_arlen} + 9'd1) << s_axi_arsize;
   assign w_end       = w_addr_ext + w_bytes - {{ADDR_WIDTH{1'b0}}, 1'b1};
   assign w_base_ext  = (ADDR_WIDTH+1)'(i_addr_base);
   assign w_limit_ext = (ADDR_WIDTH+1)'(i_addr_limit);
   assign w_ar_err    = (s_axi_arburst != AXI_BURST_INCR) |
                        (w_addr_ext < w_base_ext) | (w_end > w_limit_ext);

   assign s_axi_arready = ~rst & ~w_full;
   assign w_push        = s_axi_arvalid & s_axi_arready;

   assign w_beat_hs = r_rvalid & s_axi_rready;
   // Load the next burst either from idle or directly behind an rlast beat.
   assign w_pop     = ~w_empty & ((r_state == ST_IDLE) | (w_beat_hs & r_rlast));

   // Clear has priority over the beat advancing the pattern.
   assign w_pat_next = i_clear ? 32'd0 : (w_beat_hs ? r_pat_cnt + 32'd1 : r_pat_cnt);

   assign w_head_id  = w_head[ENTRY_W-1 -: ID_WIDTH];
   assign w_head_len = w_head[8:1];
   assign w_head_err = w_head[0];

   rd_req_fifo #(
      .W  (ENTRY_W),
      .AW (FIFO_AW)
   ) u_req_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  ({s_axi_arid, s_axi_arlen, w_ar_err}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_rid       <= '0;
         r_rdata     <= '0;
         r_rresp     <= AXI_RESP_OKAY;
         r_rlast     <= 1'b0;
         r_rvalid    <= 1'b0;
         r_len       <= '0;
         r_beat      <= '0;
         r_err       <= 1'b0;
         r_pat_cnt   <= '0;
         r_burst_cnt <= '0;
         r_beat_cnt  <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_pat_cnt <= w_pat_next;
         // Data only moves on a beat, a new burst or a clear, so it is
         // stable while the master stalls.
         if (w_pop || w_beat_hs || i_clear)
            r_rdata <= {LANES{i_init_data + w_pat_next}};

         if (w_pop) begin
            r_state  <= ST_BURST;
            r_rid    <= w_head_id;
            r_len    <= w_head_len;
            r_err    <= w_head_err;
            r_rresp  <= w_head_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            r_beat   <= '0;
            r_rlast  <= (w_head_len == 8'd0);
            r_rvalid <= 1'b1;
         end else if (r_state == ST_BURST && w_beat_hs) begin
            if (r_rlast) begin
               r_state  <= ST_IDLE;
               r_rvalid <= 1'b0;
               r_rlast  <= 1'b0;
            end else begin
               r_beat  <= r_beat + 8'd1;
               r_rlast <= ((r_beat + 8'd1) == r_len);
            end
         end

         if (i_clear) begin
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
            r_err_cnt   <= '0;
         end else if (w_beat_hs) begin
            r_beat_cnt <= r_beat_cnt + 40'd1;
            if (r_rlast) begin
               r_burst_cnt <= r_burst_cnt + 32'd1;
               if (r_err) r_err_cnt <= sat_inc16(r_err_cnt);
            end
         end
      end
   end

   assign s_axi_rid     = r_rid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rlast   = r_rlast;
   assign s_axi_rvalid  = r_rvalid;
   assign o_burst_count = r_burst_cnt;
   assign o_beat_count  = r_beat_cnt;
   assign o_err_count   = r_err_cnt;

endmodule

// File: tb/tb_axi_slave_rd_responder.sv
module tb_axi_slave_rd_responder;

   localparam int DW    = 512;
   localparam int LANES = DW / 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    s_axi_arid;
   logic [63:0]   s_axi_araddr;
   logic [7:0]    s_axi_arlen;
   logic [2:0]    s_axi_arsize;
   logic [1:0]    s_axi_arburst;
   logic [7:0]    s_axi_aruser;
   logic          s_axi_arvalid;
   logic          s_axi_arready;
   logic [1:0]    s_axi_rid;
   logic [DW-1:0] s_axi_rdata;
   logic [1:0]    s_axi_rresp;
   logic          s_axi_rlast;
   logic          s_axi_rvalid;
   logic          s_axi_rready;
   logic [31:0]   i_init_data;
   logic [63:0]   i_addr_base;
   logic [63:0]   i_addr_limit;
   logic          i_clear;
   logic [31:0]   o_burst_count;
   logic [39:0]   o_beat_count;
   logic [15:0]   o_err_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [31:0] got_lane [$];
   logic        got_eq   [$];
   logic [1:0]  got_id   [$];
   logic [1:0]  got_resp [$];
   logic        got_last [$];
   int          got_cyc  [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axi_slave_rd_responder dut (
      .clk           (clk),
      .rst           (rst),
      .s_axi_arid    (s_axi_arid),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arlen   (s_axi_arlen),
      .s_axi_arsize  (s_axi_arsize),
      .s_axi_arburst (s_axi_arburst),
      .s_axi_aruser  (s_axi_aruser),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rid     (s_axi_rid),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rlast   (s_axi_rlast),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .i_init_data   (i_init_data),
      .i_addr_base   (i_addr_base),
      .i_addr_limit  (i_addr_limit),
      .i_clear       (i_clear),
      .o_burst_count (o_burst_count),
      .o_beat_count  (o_beat_count),
      .o_err_count   (o_err_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
   endtask

   // Present one AR and hold it until accepted (bounded).
   task automatic issue_ar(input logic [1:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
      s_axi_arid    = id;
      s_axi_araddr  = addr;
      s_axi_arlen   = len;
      s_axi_arsize  = 3'd6;
      s_axi_arburst = burst;
      s_axi_arvalid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (s_axi_arready) begin
            step();
            s_axi_arvalid = 1'b0;
            return;
         end
         step();
      end
      s_axi_arvalid = 1'b0;
      n_checks++;
      n_fail++;
      $display("FAIL ar_accept_timeout: arready never high for id %0d", id);
   endtask

   // Record beats with rready held high.
   task automatic collect(input int n, output int got);
      got_lane.delete(); got_eq.delete(); got_id.delete();
      got_resp.delete(); got_last.delete(); got_cyc.delete();
      s_axi_rready = 1'b1;
      got = 0;
      for (int c = 0; c < 60 && got < n; c++) begin
         if (s_axi_rvalid) begin
            got_lane.push_back(s_axi_rdata[31:0]);
            got_eq.push_back(s_axi_rdata == {LANES{s_axi_rdata[31:0]}});
            got_id.push_back(s_axi_rid);
            got_resp.push_back(s_axi_rresp);
            got_last.push_back(s_axi_rlast);
            got_cyc.push_back(cyc);
            got++;
         end
         step();
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if ({s_axi_arready, s_axi_rvalid, s_axi_rlast} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: arready/rvalid/rlast=%b expected 000",
                  {s_axi_arready, s_axi_rvalid, s_axi_rlast});
      end
      n_checks++;
      if (s_axi_rid !== 2'd0 || s_axi_rresp !== 2'd0 || s_axi_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_data: rid=%0d rresp=%0d rdata0=%h expected zeros",
                  s_axi_rid, s_axi_rresp, s_axi_rdata[31:0]);
      end
      n_checks++;
      if (o_burst_count !== 32'd0 || o_beat_count !== 40'd0 || o_err_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_counters: bursts=%0d beats=%0d errs=%0d expected 0",
                  o_burst_count, o_beat_count, o_err_count);
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (s_axi_arready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_arready: got %b expected 1", s_axi_arready);
      end
   endtask

   task automatic test_single_burst();
      int got;
      i_init_data = 32'h10;
      issue_ar(2'd1, 64'h1000, 8'd3, 2'b01);
      collect(4, got);
      n_checks++;
      if (got != 4) begin
         n_fail++;
         $display("FAIL single_beats: got %0d beats expected 4", got);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_lane[i] !== 32'h10 + 32'(i) || got_eq[i] !== 1'b1 || got_id[i] !== 2'd1 ||
                got_resp[i] !== 2'b00 || got_last[i] !== (i == 3)) begin
               n_fail++;
               $display("FAIL single_beat%0d: lane=%h eq=%b id=%0d resp=%0d last=%b expected lane=%h eq=1 id=1 resp=0 last=%b",
                        i, got_lane[i], got_eq[i], got_id[i], got_resp[i], got_last[i],
                        32'h10 + 32'(i), (i == 3));
            end
         end
      end
      n_checks++;
      if (o_burst_count !== 32'd1 || o_beat_count !== 40'd4 || s_axi_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_counts: bursts=%0d beats=%0d rvalid=%b expected 1 4 0",
                  o_burst_count, o_beat_count, s_axi_rvalid);
      end
   endtask

   task automatic test_back_to_back();
      int got;
      logic [1:0] exp_id [3]   = '{2'd2, 2'd2, 2'd3};
      logic       exp_last [3] = '{1'b0, 1'b1, 1'b1};
      pulse_clear();
      i_init_data = 32'h10;
      issue_ar(2'd2, 64'h1000, 8'd1, 2'b01);
      issue_ar(2'd3, 64'h2000, 8'd0, 2'b01);
      collect(3, got);
      n_checks++;
      if (got != 3) begin
         n_fail++;
         $display("FAIL b2b_beats: got %0d beats expected 3", got);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got_id[i] !== exp_id[i] || got_last[i] !== exp_last[i] ||
                got_lane[i] !== 32'h10 + 32'(i)) begin
               n_fail++;
               $display("FAIL b2b_beat%0d: id=%0d last=%b lane=%h expected id=%0d last=%b lane=%h",
                        i, got_id[i], got_last[i], got_lane[i], exp_id[i], exp_last[i],
                        32'h10 + 32'(i));
            end
         end
         n_checks++;
         if (got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1) begin
            n_fail++;
            $display("FAIL b2b_gap: beat cycles %0d %0d %0d expected consecutive",
                     got_cyc[0], got_cyc[1], got_cyc[2]);
         end
      end
   endtask

   task automatic test_backpressure();
      int          hs = 0;
      int          n_last = 0;
      logic        stalled = 1'b0;
      logic [DW-1:0] sv_data;
      logic [1:0]  sv_id;
      logic        sv_last;
      logic [31:0] last_lane = '0;
      int          stab_err = 0;
      pulse_clear();
      i_init_data = 32'h20;
      s_axi_rready = 1'b0;
      issue_ar(2'd0, 64'h1000, 8'd7, 2'b01);
      for (int c = 0; c < 60 && hs < 8; c++) begin
         s_axi_rready = ((c % 3) == 0);
         if (stalled && s_axi_rvalid &&
             (s_axi_rdata !== sv_data || s_axi_rid !== sv_id || s_axi_rlast !== sv_last))
            stab_err++;
         stalled = s_axi_rvalid & ~s_axi_rready;
         sv_data = s_axi_rdata;
         sv_id   = s_axi_rid;
         sv_last = s_axi_rlast;
         if (s_axi_rvalid && s_axi_rready) begin
            hs++;
            last_lane = s_axi_rdata[31:0];
            if (s_axi_rlast) n_last++;
         end
         step();
      end
      s_axi_rready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (s_axi_rvalid) hs++;
         step();
      end
      n_checks++;
      if (stab_err != 0) begin
         n_fail++;
         $display("FAIL bp_stable: %0d stalled cycles changed outputs, expected 0", stab_err);
      end
      n_checks++;
      if (hs != 8 || n_last != 1) begin
         n_fail++;
         $display("FAIL bp_handshakes: hs=%0d rlast_hs=%0d expected 8 and 1", hs, n_last);
      end
      n_checks++;
      if (last_lane !== 32'h27) begin
         n_fail++;
         $display("FAIL bp_final_lane: got %h expected 00000027", last_lane);
      end
   endtask

   task automatic test_fifo_full();
      int acc = 0;
      int got;
      logic [1:0] first_id;
      logic [1:0] exp_id [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      pulse_clear();
      s_axi_rready  = 1'b0;
      s_axi_araddr  = 64'h1000;
      s_axi_arlen   = 8'd0;
      s_axi_arsize  = 3'd6;
      s_axi_arburst = 2'b01;
      s_axi_arid    = 2'd0;
      s_axi_arvalid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (s_axi_arready) acc++;
         step();
         s_axi_arid = 2'(acc);
      end
      n_checks++;
      if (acc != 5 || s_axi_arready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_accept: accepted=%0d arready=%b expected 5 and 0", acc, s_axi_arready);
      end
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b1;
      first_id = s_axi_rid;
      n_checks++;
      if (s_axi_arready !== 1'b0 || s_axi_rvalid !== 1'b1 || s_axi_rlast !== 1'b1) begin
         n_fail++;
         $display("FAIL full_pre_pop: arready=%b rvalid=%b rlast=%b expected 0 1 1",
                  s_axi_arready, s_axi_rvalid, s_axi_rlast);
      end
      step();
      n_checks++;
      if (s_axi_arready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_reassert: arready=%b expected 1", s_axi_arready);
      end
      collect(4, got);
      n_checks++;
      if (got != 4 || first_id !== 2'd0) begin
         n_fail++;
         $display("FAIL full_drain: beats=%0d first_id=%0d expected 4 and 0", got, first_id);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_id[i] !== exp_id[i]) begin
               n_fail++;
               $display("FAIL full_order%0d: rid=%0d expected %0d", i, got_id[i], exp_id[i]);
            end
         end
      end
   endtask

   task automatic test_errors();
      int got;
      logic [63:0] addr [5]  = '{64'h0FC0, 64'h0000, 64'h0F80, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0080};
      logic [1:0]  bt [5]    = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
      logic [63:0] lim [5]   = '{64'hFFF, 64'hFFF, 64'hFFF, '1, 64'hFFF};
      logic [63:0] base [5]  = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h100};
      logic [1:0]  eresp [5] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10};
      logic [15:0] ecnt [5]  = '{16'd1, 16'd2, 16'd2, 16'd3, 16'd4};
      pulse_clear();
      for (int k = 0; k < 5; k++) begin
         i_addr_base  = base[k];
         i_addr_limit = lim[k];
         issue_ar(2'd1, addr[k], 8'd1, bt[k]);
         collect(2, got);
         n_checks++;
         if (got != 2 || got_resp[0] !== eresp[k] || got_resp[1] !== eresp[k] ||
             got_last[1] !== 1'b1 || o_err_count !== ecnt[k]) begin
            n_fail++;
            $display("FAIL err_case%0d: beats=%0d resp=%0d,%0d errs=%0d expected 2 beats resp=%0d errs=%0d",
                     k, got, got_resp[0], got_resp[1], o_err_count, eresp[k], ecnt[k]);
         end
      end
      i_addr_base  = '0;
      i_addr_limit = '1;
   endtask

   task automatic test_clear();
      int hs = 0;
      logic [31:0] lanes [4];
      logic [31:0] exp [4] = '{32'h40, 32'h41, 32'h40, 32'h41};
      pulse_clear();
      i_init_data  = 32'h40;
      s_axi_rready = 1'b1;
      issue_ar(2'd2, 64'h1000, 8'd3, 2'b01);
      for (int c = 0; c < 20 && hs < 4; c++) begin
         i_clear = 1'b0;
         if (s_axi_rvalid) begin
            lanes[hs] = s_axi_rdata[31:0];
            if (hs == 1) i_clear = 1'b1;
            hs++;
         end
         step();
      end
      i_clear = 1'b0;
      n_checks++;
      if (hs != 4) begin
         n_fail++;
         $display("FAIL clear_beats: got %0d expected 4", hs);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (lanes[i] !== exp[i]) begin
               n_fail++;
               $display("FAIL clear_lane%0d: got %h expected %h", i, lanes[i], exp[i]);
            end
         end
      end
      n_checks++;
      if (o_beat_count !== 40'd2 || o_burst_count !== 32'd1) begin
         n_fail++;
         $display("FAIL clear_counts: beats=%0d bursts=%0d expected 2 and 1",
                  o_beat_count, o_burst_count);
      end
   endtask

   task automatic test_reset_mid();
      s_axi_rready = 1'b0;
      issue_ar(2'd3, 64'h1000, 8'd7, 2'b01);
      issue_ar(2'd1, 64'h2000, 8'd3, 2'b01);
      step();
      n_checks++;
      if (s_axi_rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_pre: rvalid=%b expected 1", s_axi_rvalid);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0 || s_axi_arready !== 1'b0 ||
          o_beat_count !== 40'd0 || s_axi_rdata !== '0) begin
         n_fail++;
         $display("FAIL rstmid_async: rvalid=%b rlast=%b arready=%b beats=%0d expected 0 0 0 0",
                  s_axi_rvalid, s_axi_rlast, s_axi_arready, o_beat_count);
      end
      step();
      rst = 1'b0;
      s_axi_rready = 1'b1;
      step();
      n_checks++;
      if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_release: arready=%b rvalid=%b expected 1 0", s_axi_arready, s_axi_rvalid);
      end
      step();
      step();
      n_checks++;
      if (s_axi_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_fifo_empty: rvalid=%b expected 0", s_axi_rvalid);
      end
   endtask

   initial begin
      rst = 1'b1;
      s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
      s_axi_arburst = 2'b01; s_axi_aruser = 8'hA5; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0; i_init_data = 32'h10; i_addr_base = '0;
      i_addr_limit = '1; i_clear = 1'b0;
      step();
      step();
      test_reset();
      test_single_burst();
      test_back_to_back();
      test_backpressure();
      test_fifo_full();
      test_errors();
      test_clear();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
